// File: rtl/sampler_pkg.sv
// sampler_pkg: shared types and defaults for the keyboard sample player
//   state_t        : player FSM states (IDLE, PLAY)
//   ONESHOT / GATE : playback mode selectors for GATE_MODE
//   DEF_*          : default sizing parameters
package sampler_pkg;
   typedef enum logic {IDLE, PLAY} state_t;
   localparam int ONESHOT = 0;
   localparam int GATE = 1;
   localparam int DEF_N_KEYS = 16;
   localparam int DEF_SLOT_W = 12;
   localparam int DEF_DATA_W = 8;
   localparam int DEF_SAMPLE_DIV = 6250;
endpackage

// File: rtl/key_edge_prio.sv
// key_edge_prio: key press edge detector with fixed-priority winner select
//   CLOCK_50 : system clock
//   keys     : key levels, synchronous to CLOCK_50
//   any_rise : at least one key went high this cycle
//   winner   : lowest-index key that went high this cycle
module key_edge_prio
   import sampler_pkg::*;
#(
   parameter int N_KEYS = DEF_N_KEYS,
   localparam int VID_W = $clog2(N_KEYS)
) (
   input  logic              CLOCK_50,
   input  logic [N_KEYS-1:0] keys,
   output logic              any_rise,
   output logic [VID_W-1:0]  winner
);
   logic [N_KEYS-1:0] keys_q;
   logic [N_KEYS-1:0] rise;
   // Loads unconditionally, so keys held through reset are already "seen"
   always_ff @(posedge CLOCK_50)
      keys_q <= keys;
   assign rise = keys & ~keys_q;
   assign any_rise = |rise;
   // Scan high to low so the lowest set index is the last one written
   always_comb begin
      winner = '0;
      for (int i = N_KEYS - 1; i >= 0; i--)
         if (rise[i]) winner = VID_W'(i);
   end
endmodule

// File: rtl/sample_voice_player.sv
// sample_voice_player: key-triggered voice player walking per-voice ROM slots
//   CLOCK_50    : system clock
//   reset       : synchronous active-high reset
//   keys        : key levels, bit 0 highest priority
//   rom_en      : ROM read strobe, one cycle per sample
//   rom_addr    : {voice_id, offset}
//   rom_data    : ROM data, valid the cycle after rom_en
//   audio_out   : current sample, held between updates
//   audio_valid : one-cycle pulse when audio_out updates
//   voice_id    : active voice
//   busy        : high while playing
module sample_voice_player
   import sampler_pkg::*;
#(
   parameter int N_KEYS = DEF_N_KEYS,
   parameter int SLOT_W = DEF_SLOT_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int SAMPLE_DIV = DEF_SAMPLE_DIV,
   parameter int GATE_MODE = ONESHOT,
   localparam int VID_W = $clog2(N_KEYS)
) (
   input  logic                    CLOCK_50,
   input  logic                    reset,
   input  logic [N_KEYS-1:0]       keys,
   output logic                    rom_en,
   output logic [VID_W+SLOT_W-1:0] rom_addr,
   input  logic [DATA_W-1:0]       rom_data,
   output logic [DATA_W-1:0]       audio_out,
   output logic                    audio_valid,
   output logic [VID_W-1:0]        voice_id,
   output logic                    busy
);
   localparam int DIV_W = $clog2(SAMPLE_DIV);
   state_t            state;
   logic [SLOT_W-1:0] offset;
   logic [DIV_W-1:0]  div;
   logic              rd_pend;
   logic              zero_pend;
   logic              any_rise;
   logic [VID_W-1:0]  winner;
   logic              rel;
   logic              last;
   key_edge_prio #(.N_KEYS(N_KEYS)) u_prio (
      .CLOCK_50 (CLOCK_50),
      .keys     (keys),
      .any_rise (any_rise),
      .winner   (winner)
   );
   assign busy = (state == PLAY);
   assign rel = (GATE_MODE == GATE) && busy && !keys[voice_id] && !any_rise;
   // offset holds the next word to fetch, so a wrap to 0 right after a fetch marks the slot's final word
   assign last = (GATE_MODE == ONESHOT) && rom_en && (offset == '0);
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state <= IDLE;
         voice_id <= '0;
         offset <= '0;
         div <= '0;
         rom_en <= 1'b0;
         rom_addr <= '0;
         rd_pend <= 1'b0;
         zero_pend <= 1'b0;
         audio_out <= '0;
         audio_valid <= 1'b0;
      end else begin
         rd_pend <= rom_en;
         audio_valid <= rd_pend || zero_pend;
         audio_out <= rd_pend ? rom_data : zero_pend ? '0 : audio_out;
         // Release silence waits behind any in-flight fetch so sample order is kept
         zero_pend <= rel || (zero_pend && rd_pend && !any_rise);
         if (any_rise) begin
            state <= PLAY;
            voice_id <= winner;
            rom_en <= 1'b1;
            rom_addr <= {winner, {SLOT_W{1'b0}}};
            offset <= SLOT_W'(1);
            div <= DIV_W'(SAMPLE_DIV - 1);
         end else if (busy) begin
            if (rel || last) begin
               state <= IDLE;
               rom_en <= 1'b0;
            end else if (div == '0) begin
               rom_en <= 1'b1;
               rom_addr <= {voice_id, offset};
               offset <= offset + 1'b1;
               div <= DIV_W'(SAMPLE_DIV - 1);
            end else begin
               rom_en <= 1'b0;
               div <= div - 1'b1;
            end
         end else begin
            rom_en <= 1'b0;
         end
      end
   end
endmodule
